rv32_fetch: RTL and testbench

- Instruction-fetch stage that sits directly in front of the instruction memory.
- Owns the program counter and drives the memory read address every cycle.
- Absorbs the memory's 1-cycle registered read latency.
- Delivers PC-tagged instructions to decode over a valid/ready handshake, with a 2-entry buffer for backpressure and a redirect port for branches and jumps.

---
 rtl/rv32_pkg.sv | 17 +
 rtl/rv32_fetch_fifo.sv | 59 +++++
 rtl/rv32_fetch.sv | 92 +++++++++
 tb/tb_rv32_fetch.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 types and constants used by the instruction-fetch slice.
package rv32_pkg;

    localparam int unsigned RV32_XLEN             = 32;
    localparam int unsigned RV32_DMEM_AW          = 13;
    localparam int unsigned RV32_FETCH_FIFO_DEPTH = 2;
    localparam int unsigned RV32_FETCH_CNT_W      = 2;

    typedef logic [RV32_XLEN-1:0]    rv32_data_t;
    typedef logic [RV32_DMEM_AW-1:0] rv32_dmem_addr_t;

    typedef struct packed {
        rv32_dmem_addr_t pc;
        rv32_data_t      instr;
    } rv32_fetch_entry_t;

endpackage

// File: rtl/rv32_fetch_fifo.sv
// Two-entry fetch buffer of PC-tagged instructions with flush.
// Entry 0 is always the head, so the output needs no read mux.
module rv32_fetch_fifo
    import rv32_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  rv32_fetch_entry_t           din,
    input  logic                        pop,
    input  logic                        flush,
    output rv32_fetch_entry_t           head,
    output logic [RV32_FETCH_CNT_W-1:0] count
);

    rv32_fetch_entry_t               entry_q [RV32_FETCH_FIFO_DEPTH];
    logic [RV32_FETCH_CNT_W-1:0]     count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            count_q    <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == '0) entry_q[0] <= din;
                    else               entry_q[1] <= din;
                    count_q <= count_q + RV32_FETCH_CNT_W'(1);
                end
                2'b01: begin
                    entry_q[0] <= entry_q[1];
                    count_q    <= count_q - RV32_FETCH_CNT_W'(1);
                end
                2'b11: begin
                    // Simultaneous push/pop keeps occupancy; only the head shifts.
                    if (count_q == RV32_FETCH_CNT_W'(RV32_FETCH_FIFO_DEPTH)) begin
                        entry_q[0] <= entry_q[1];
                        entry_q[1] <= din;
                    end else begin
                        entry_q[0] <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = entry_q[0];
    assign count = count_q;

    // The issue rule upstream must never let a push land on a full buffer.
    overflow_chk: assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && !flush &&
          count_q == RV32_FETCH_CNT_W'(RV32_FETCH_FIFO_DEPTH)));

endmodule

// File: rtl/rv32_fetch.sv
// Instruction-fetch stage: PC, issue into 1-cycle-latency imem, 2-entry output buffer.
// Define RV32_FETCH_PERF_EN to add stall and redirect performance counters.
module rv32_fetch
    import rv32_pkg::*;
#(
    parameter rv32_dmem_addr_t RESET_PC   = 13'h0000,
    parameter int unsigned     FIFO_DEPTH = RV32_FETCH_FIFO_DEPTH
) (
    input  logic            clock,
    input  logic            reset,
    output rv32_dmem_addr_t imem_rdaddress,
    input  rv32_data_t      imem_q,
    input  logic            redirect_valid,
    input  rv32_dmem_addr_t redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output rv32_data_t      instr,
    output rv32_dmem_addr_t instr_pc
`ifdef RV32_FETCH_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_redirect_cnt
`endif
);

    localparam int unsigned OCC_W = 3;

    rv32_dmem_addr_t             pc_q;
    rv32_dmem_addr_t             pc_prev_q;
    logic                        inflight_q;
    logic                        pop;
    logic                        issue;
    logic [OCC_W-1:0]            occ;
    logic [RV32_FETCH_CNT_W-1:0] count;
    rv32_fetch_entry_t           push_entry;
    rv32_fetch_entry_t           head;

    // Occupancy after this edge if nothing new were issued; leave room for one more.
    assign pop   = instr_valid & instr_ready;
    assign occ   = OCC_W'(count) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign issue = !redirect_valid && (occ <= OCC_W'(FIFO_DEPTH - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            pc_prev_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (redirect_valid) begin
                pc_q <= redirect_pc;
            end else if (issue) begin
                pc_q      <= pc_q + RV32_DMEM_AW'(1);
                pc_prev_q <= pc_q;
            end
        end
    end

    assign push_entry = '{pc: pc_prev_q, instr: imem_q};

    rv32_fetch_fifo u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (inflight_q),
        .din   (push_entry),
        .pop   (pop),
        .flush (redirect_valid),
        .head  (head),
        .count (count)
    );

    assign imem_rdaddress = pc_q;
    assign instr_valid    = (count != '0);
    assign instr          = head.instr;
    assign instr_pc       = head.pc;

`ifdef RV32_FETCH_PERF_EN
    // Saturating event counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_stall_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (instr_valid && !instr_ready && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (redirect_valid && perf_redirect_cnt != '1)
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rv32_fetch.sv
// Directed table-driven bench for rv32_fetch with a 1-cycle registered imem model.
module tb_rv32_fetch;
    import rv32_pkg::*;

    typedef struct {
        logic        redir;
        logic [12:0] rpc;
        logic        ready;
        logic        exp_valid;
        logic [12:0] exp_pc;
        logic [12:0] exp_addr;
    } vec_t;

    localparam int NVEC = 26;
    localparam int NACC = 13;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    rv32_dmem_addr_t imem_rdaddress;
    rv32_data_t      imem_q = '0;
    logic            redirect_valid = 1'b0;
    rv32_dmem_addr_t redirect_pc = '0;
    logic            instr_valid;
    logic            instr_ready = 1'b0;
    rv32_data_t      instr;
    rv32_dmem_addr_t instr_pc;
`ifdef RV32_FETCH_PERF_EN
    logic [31:0]     perf_stall_cnt;
    logic [31:0]     perf_redirect_cnt;
`endif

    int errors = 0;
    int checks = 0;

    vec_t        vecs [NVEC];
    logic [12:0] exp_acc [NACC];
    logic [12:0] acc_q [$];

    rv32_fetch dut (
        .clock          (clock),
        .reset          (reset),
        .imem_rdaddress (imem_rdaddress),
        .imem_q         (imem_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
`ifdef RV32_FETCH_PERF_EN
        ,
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    always #5 clock = ~clock;

    // Instruction memory: tagged data one cycle after the address.
    always_ff @(posedge clock) imem_q <= {19'h5A5A5, imem_rdaddress};

    function automatic vec_t mk(input logic redir, input logic [12:0] rpc, input logic rdy,
                                input logic ev, input logic [12:0] epc, input logic [12:0] ea);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.ready = rdy;
        v.exp_valid = ev; v.exp_pc = epc; v.exp_addr = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // C0 is the first cycle after reset release; cycles 5-9 stall, redirects at 14 and 19.
        vecs[0]  = mk(0, 13'h0,    1, 0, 13'h0,    13'h0);
        vecs[1]  = mk(0, 13'h0,    1, 0, 13'h0,    13'h1);
        vecs[2]  = mk(0, 13'h0,    1, 1, 13'h0,    13'h2);
        vecs[3]  = mk(0, 13'h0,    1, 1, 13'h1,    13'h3);
        vecs[4]  = mk(0, 13'h0,    1, 1, 13'h2,    13'h4);
        vecs[5]  = mk(0, 13'h0,    0, 1, 13'h3,    13'h5);
        vecs[6]  = mk(0, 13'h0,    0, 1, 13'h3,    13'h5);
        vecs[7]  = mk(0, 13'h0,    0, 1, 13'h3,    13'h5);
        vecs[8]  = mk(0, 13'h0,    0, 1, 13'h3,    13'h5);
        vecs[9]  = mk(0, 13'h0,    0, 1, 13'h3,    13'h5);
        vecs[10] = mk(0, 13'h0,    1, 1, 13'h3,    13'h5);
        vecs[11] = mk(0, 13'h0,    1, 1, 13'h4,    13'h6);
        vecs[12] = mk(0, 13'h0,    1, 1, 13'h5,    13'h7);
        vecs[13] = mk(0, 13'h0,    0, 1, 13'h6,    13'h8);
        vecs[14] = mk(1, 13'h0100, 0, 1, 13'h6,    13'h8);
        vecs[15] = mk(0, 13'h0,    1, 0, 13'h0,    13'h0100);
        vecs[16] = mk(0, 13'h0,    1, 0, 13'h0,    13'h0101);
        vecs[17] = mk(0, 13'h0,    1, 1, 13'h0100, 13'h0102);
        vecs[18] = mk(0, 13'h0,    1, 1, 13'h0101, 13'h0103);
        vecs[19] = mk(1, 13'h1FFF, 1, 1, 13'h0102, 13'h0104);
        vecs[20] = mk(0, 13'h0,    1, 0, 13'h0,    13'h1FFF);
        vecs[21] = mk(0, 13'h0,    1, 0, 13'h0,    13'h0);
        vecs[22] = mk(0, 13'h0,    1, 1, 13'h1FFF, 13'h1);
        vecs[23] = mk(0, 13'h0,    1, 1, 13'h0,    13'h2);
        vecs[24] = mk(0, 13'h0,    1, 1, 13'h1,    13'h3);
        vecs[25] = mk(0, 13'h0,    1, 1, 13'h2,    13'h4);
        exp_acc = '{13'h0, 13'h1, 13'h2, 13'h3, 13'h4, 13'h5,
                    13'h0100, 13'h0101, 13'h0102, 13'h1FFF, 13'h0, 13'h1, 13'h2};

        repeat (3) @(negedge clock);
        #1;
        check("reset valid", 32'(instr_valid), 32'd0);
        check("reset instr", instr, 32'd0);
        check("reset pc", 32'(instr_pc), 32'd0);
        check("reset addr", 32'(imem_rdaddress), 32'd0);
`ifdef RV32_FETCH_PERF_EN
        check("reset perf stall", perf_stall_cnt, 32'd0);
        check("reset perf redirect", perf_redirect_cnt, 32'd0);
`endif
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            instr_ready    = vecs[i].ready;
            #1;
            check($sformatf("c%0d valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
            check($sformatf("c%0d addr", i), 32'(imem_rdaddress), 32'(vecs[i].exp_addr));
            if (vecs[i].exp_valid) begin
                check($sformatf("c%0d pc", i), 32'(instr_pc), 32'(vecs[i].exp_pc));
                check($sformatf("c%0d instr", i), instr, {19'h5A5A5, vecs[i].exp_pc});
            end
`ifdef RV32_FETCH_PERF_EN
            if (i == 10) begin
                check("perf stall after backpressure", perf_stall_cnt, 32'd5);
                check("perf redirect before redirect", perf_redirect_cnt, 32'd0);
            end
`endif
            if (instr_valid && vecs[i].ready) acc_q.push_back(instr_pc);
            @(negedge clock);
        end
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;

        check("accepted count", 32'(acc_q.size()), 32'(NACC));
        for (int k = 0; k < NACC && k < acc_q.size(); k++)
            check($sformatf("accepted[%0d]", k), 32'(acc_q[k]), 32'(exp_acc[k]));
`ifdef RV32_FETCH_PERF_EN
        check("perf stall total", perf_stall_cnt, 32'd7);
        check("perf redirect total", perf_redirect_cnt, 32'd2);
`endif

        // Reset asserted between edges while the stream is running.
        #1;
        check("pre-reset valid", 32'(instr_valid), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("midreset valid", 32'(instr_valid), 32'd0);
        check("midreset instr", instr, 32'd0);
        check("midreset pc", 32'(instr_pc), 32'd0);
        check("midreset addr", 32'(imem_rdaddress), 32'd0);
`ifdef RV32_FETCH_PERF_EN
        check("midreset perf stall", perf_stall_cnt, 32'd0);
        check("midreset perf redirect", perf_redirect_cnt, 32'd0);
`endif
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("restart c0 valid", 32'(instr_valid), 32'd0);
        check("restart c0 addr", 32'(imem_rdaddress), 32'd0);
        @(negedge clock);
        #1;
        check("restart c1 valid", 32'(instr_valid), 32'd0);
        @(negedge clock);
        #1;
        check("restart c2 valid", 32'(instr_valid), 32'd1);
        check("restart c2 pc", 32'(instr_pc), 32'd0);
        check("restart c2 instr", instr, {19'h5A5A5, 13'h0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
